// File: rtl/bzmusic_pkg.sv
// Shared song IDs, arbiter state codes and timing defaults for the
// buzzer music arbiter.
package bzmusic_pkg;

    localparam logic [1:0] SONG_BG    = 2'd0;
    localparam logic [1:0] SONG_CHOMP = 2'd1;
    localparam logic [1:0] SONG_GHOST = 2'd2;
    localparam logic [1:0] SONG_DEATH = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int unsigned GAP_CYC_DEF   = 2_500_000;
    localparam int unsigned SETUP_CYC_DEF = 2;
    localparam int unsigned CNT_W         = 24;

endpackage

// File: rtl/bzmusic_prio_enc.sv
// Fixed-priority encoder over the eligible song vector; the highest
// set index wins, death being the highest.
module bzmusic_prio_enc
    import bzmusic_pkg::*;
(
    input  logic [3:0] elig,
    output logic [1:0] win,
    output logic       vld
);

    always_comb begin
        win = SONG_BG;
        priority case (1'b1)
            elig[3]: win = SONG_DEATH;
            elig[2]: win = SONG_GHOST;
            elig[1]: win = SONG_CHOMP;
            default: win = SONG_BG;
        endcase
    end

    assign vld = |elig;

endmodule

// File: rtl/bzmusic_arbiter.sv
// Arbitrates game sound requests onto the single buzzer music player,
// with fixed priority, preemption, setup delay and an inter-song gap.
module bzmusic_arbiter
    import bzmusic_pkg::*;
#(
    parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
    parameter int unsigned SETUP_CYC = SETUP_CYC_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] req,
    input  logic       bg_stop,
    input  logic       mute,
    input  logic       play_done,
    output logic [1:0] sel,
    output logic       play_en,
    output logic       busy,
    output logic [1:0] cur_song
);

    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:1]       pend;
    logic             bg_on;

    logic [3:0] req_m;
    logic [3:1] pend_n;
    logic [3:1] pend_clr;
    logic       bg_n;
    logic [1:0] win;
    logic       win_vld;
    logic       restart;
    logic       preempt;
    logic       start;

    // A request for the song already in progress is not a restart,
    // except death, which restarts itself.
    always_comb begin
        req_m = req;
        if (busy && cur_song != SONG_DEATH)
            req_m[cur_song] = 1'b0;
    end

    assign pend_n = pend | req_m[3:1];
    assign bg_n   = (bg_on | req_m[0]) & ~bg_stop;

    bzmusic_prio_enc u_prio (
        .elig ({pend_n, bg_n}),
        .win  (win),
        .vld  (win_vld)
    );

    always_comb begin
        pend_clr = pend_n;
        for (int i = 1; i <= 3; i++)
            if (win == 2'(i))
                pend_clr[i] = 1'b0;
    end

    assign restart = req_m[3] && cur_song == SONG_DEATH;
    assign preempt = state == ST_PLAY && !play_done
                  && (win > cur_song || restart);
    assign start   = !mute && win_vld
                  && (state == ST_IDLE || preempt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pend     <= '0;
            bg_on    <= 1'b0;
            sel      <= SONG_BG;
            cur_song <= SONG_BG;
            play_en  <= 1'b0;
            busy     <= 1'b0;
        end else if (mute) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend    <= '0;
            bg_on   <= bg_n;
            play_en <= 1'b0;
            busy    <= 1'b0;
        end else begin
            pend  <= start ? pend_clr : pend_n;
            bg_on <= bg_n;
            if (start) begin
                state    <= ST_SETUP;
                cnt      <= SETUP_LD;
                sel      <= win;
                cur_song <= win;
                play_en  <= 1'b0;
                busy     <= 1'b1;
            end else begin
                unique case (state)
                    ST_SETUP: begin
                        if (cnt == '0) begin
                            state   <= ST_PLAY;
                            play_en <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        if (play_done) begin
                            state   <= ST_GAP;
                            play_en <= 1'b0;
                            cnt     <= GAP_LD;
                        end
                    end
                    // Leave on the last gap cycle so the gap is exactly GAP_CYC long.
                    ST_GAP: begin
                        if (cnt[CNT_W-1:1] == '0) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bzmusic_arbiter.sv
// Self-checking bench for bzmusic_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_bzmusic_arbiter;

    localparam int GAP   = 8;
    localparam int SETUP = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] req = '0;
    logic       bg_stop = 1'b0;
    logic       mute = 1'b0;
    logic       play_done = 1'b0;
    logic [1:0] sel;
    logic       play_en;
    logic       busy;
    logic [1:0] cur_song;

    int errors = 0;
    int checks = 0;

    bzmusic_arbiter #(.GAP_CYC(GAP), .SETUP_CYC(SETUP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .bg_stop   (bg_stop),
        .mute      (mute),
        .play_done (play_done),
        .sel       (sel),
        .play_en   (play_en),
        .busy      (busy),
        .cur_song  (cur_song)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending flags, a loop flag, and the current song's
    // remaining setup / gap time.
    bit m_pend[4];
    bit m_bg;
    int m_song;
    int m_sel;
    bit m_busy;
    bit m_en;
    int m_setup_left;
    int m_gap_left;

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
        m_bg = 0; m_song = 0; m_sel = 0;
        m_busy = 0; m_en = 0;
        m_setup_left = 0; m_gap_left = 0;
    endtask

    task automatic m_start(input int w);
        m_sel = w; m_song = w;
        m_busy = 1; m_en = 0;
        m_setup_left = SETUP + 1;
        m_gap_left = 0;
        if (w > 0) m_pend[w] = 0;
    endtask

    task automatic m_step(input logic [3:0] r_in, input bit stop,
                          input bit mu, input bit done);
        logic [3:0] r;
        bit bgn;
        int w;
        r = r_in;
        if (m_busy && m_song != 3) r[m_song] = 1'b0;
        bgn = (m_bg | r[0]) & !stop;
        if (mu) begin
            m_bg = bgn;
            for (int i = 1; i < 4; i++) m_pend[i] = 0;
            m_busy = 0; m_en = 0;
            m_setup_left = 0; m_gap_left = 0;
            return;
        end
        for (int i = 1; i < 4; i++) if (r[i]) m_pend[i] = 1;
        m_bg = bgn;
        w = m_bg ? 0 : -1;
        for (int i = 1; i < 4; i++) if (m_pend[i]) w = i;
        if (!m_busy) begin
            if (w >= 0) m_start(w);
        end else if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0) m_busy = 0;
        end else if (!m_en) begin
            m_setup_left--;
            if (m_setup_left == 0) m_en = 1;
        end else if (done) begin
            m_en = 0;
            m_gap_left = GAP;
        end else if (w > m_song || (r[3] && m_song == 3)) begin
            m_start(w);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m_reset();
        else m_step(req, bg_stop, mute, play_done);
    end

    always @(negedge clk) begin
        chk("mdl_sel", int'(sel), m_sel);
        chk("mdl_en", int'(play_en), int'(m_en));
        chk("mdl_busy", int'(busy), int'(m_busy));
        if (m_busy) chk("mdl_cur", int'(cur_song), m_song);
    end

    task automatic pulse_req(input logic [3:0] r);
        req = r;
        @(negedge clk);
        req = '0;
    endtask

    task automatic pulse_done();
        play_done = 1'b1;
        @(negedge clk);
        play_done = 1'b0;
    endtask

    task automatic wait_play(input string nm, input int s, input int budget);
        int n = 0;
        while (!(busy === 1'b1 && play_en === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_en"}, int'(play_en === 1'b1), 1);
        chk({nm, "_sel"}, int'(sel), s);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(busy === 1'b0), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sel", int'(sel), 0);
        chk("rst_en", int'(play_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cur", int'(cur_song), 0);
        rstn = 1'b1;
        @(negedge clk);

        // chomp: setup latency, then exact gap length
        pulse_req(4'b0010);
        chk("t1_sel", int'(sel), 1);
        chk("t1_busy", int'(busy), 1);
        chk("t1_en0", int'(play_en), 0);
        repeat (2) begin
            @(negedge clk);
            chk("t1_setup_en", int'(play_en), 0);
        end
        @(negedge clk);
        chk("t1_en1", int'(play_en), 1);
        pulse_done();
        chk("t1_done_en", int'(play_en), 0);
        chk("t1_gap_busy", int'(busy), 1);
        repeat (GAP - 1) begin
            @(negedge clk);
            chk("t1_gap_busy", int'(busy), 1);
        end
        @(negedge clk);
        chk("t1_idle", int'(busy), 0);

        // chomp+death together, then death restart, then chomp
        pulse_req(4'b1010);
        chk("t3_sel", int'(sel), 3);
        wait_play("t3_death", 3, 10);
        pulse_req(4'b1000);
        chk("t3_rst_en", int'(play_en), 0);
        chk("t3_rst_sel", int'(sel), 3);
        wait_play("t3_death2", 3, 10);
        pulse_done();
        wait_play("t3_chomp", 1, 30);
        pulse_done();
        wait_idle("t3_idle", 20);

        // ghost preempts background, background resumes
        pulse_req(4'b0001);
        wait_play("t2_bg", 0, 10);
        pulse_req(4'b0100);
        chk("t2_sel", int'(sel), 2);
        chk("t2_en0", int'(play_en), 0);
        repeat (2) begin
            @(negedge clk);
            chk("t2_setup_en", int'(play_en), 0);
        end
        @(negedge clk);
        chk("t2_ghost_en", int'(play_en), 1);
        chk("t2_ghost_sel", int'(sel), 2);
        pulse_done();
        wait_play("t2_bg_again", 0, 30);

        // bg_stop: current loop finishes, no replay
        bg_stop = 1'b1;
        @(negedge clk);
        bg_stop = 1'b0;
        chk("t5_still_en", int'(play_en), 1);
        pulse_done();
        wait_idle("t5_idle", 20);
        repeat (20) @(negedge clk);
        chk("t5_no_replay", int'(busy), 0);

        // mute during death with chomp pending; bg resumes after mute
        pulse_req(4'b0001);
        wait_play("t4_bg", 0, 10);
        pulse_req(4'b1010);
        chk("t4_sel", int'(sel), 3);
        wait_play("t4_death", 3, 10);
        mute = 1'b1;
        @(negedge clk);
        chk("t4_mute_en", int'(play_en), 0);
        chk("t4_mute_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        chk("t4_mute_hold", int'(play_en), 0);
        mute = 1'b0;
        @(negedge clk);
        chk("t4_resume_sel", int'(sel), 0);
        chk("t4_resume_busy", int'(busy), 1);
        wait_play("t4_bg_play", 0, 10);

        // asynchronous reset mid-play
        #2 rstn = 1'b0;
        #1;
        chk("t6_sel", int'(sel), 0);
        chk("t6_en", int'(play_en), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_cur", int'(cur_song), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_replay", int'(busy), 0);

        // randomized traffic, model-checked every cycle
        for (int c = 0; c < 4000; c++) begin
            logic [3:0] r;
            for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 13) == 0);
            req = r;
            bg_stop = ($urandom_range(0, 40) == 0);
            play_done = ($urandom_range(0, 9) == 0);
            if (mute) mute = ($urandom_range(0, 5) != 0);
            else mute = ($urandom_range(0, 150) == 0);
            @(negedge clk);
        end
        req = '0;
        bg_stop = 1'b0;
        play_done = 1'b0;
        mute = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
